// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction FIFO feeding a registered RV32I decoder.
// Adds illegal-instruction flagging, pipeline flush and a sticky halt on ECALL.
// Define DECODE_RV32M_EN to decode the RV32M multiply/divide group.
module decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_ir,
  input  logic [PC_W-1:0]         in_pc,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PC_W-1:0]         out_pc,
  output logic [4:0]              out_srcreg1_num,
  output logic [4:0]              out_srcreg2_num,
  output logic [4:0]              out_dstreg_num,
  output logic [31:0]             out_imm,
  output logic [5:0]              out_alucode,
  output logic [1:0]              out_aluop1_type,
  output logic [1:0]              out_aluop2_type,
  output logic                    out_reg_we,
  output logic                    out_is_load,
  output logic                    out_is_store,
  output logic                    out_is_halt,
  output logic                    out_illegal,
  output logic                    halted,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // ALU and operand-type encodings match define.vh.
  localparam logic [5:0] AluLui  = 6'd0,  AluJal  = 6'd1,  AluJalr = 6'd2;
  localparam logic [5:0] AluBeq  = 6'd3,  AluBne  = 6'd4,  AluBlt  = 6'd5;
  localparam logic [5:0] AluBge  = 6'd6,  AluBltu = 6'd7,  AluBgeu = 6'd8;
  localparam logic [5:0] AluLb   = 6'd9,  AluLh   = 6'd10, AluLw   = 6'd11;
  localparam logic [5:0] AluLbu  = 6'd12, AluLhu  = 6'd13, AluSb   = 6'd14;
  localparam logic [5:0] AluSh   = 6'd15, AluSw   = 6'd16, AluAdd  = 6'd17;
  localparam logic [5:0] AluSub  = 6'd18, AluXor  = 6'd19, AluOr   = 6'd20;
  localparam logic [5:0] AluAnd  = 6'd21, AluSll  = 6'd22, AluSrl  = 6'd23;
  localparam logic [5:0] AluSra  = 6'd24, AluSlt  = 6'd25, AluSltu = 6'd26;
  localparam logic [5:0] AluNop  = 6'd63;
`ifdef DECODE_RV32M_EN
  localparam logic [5:0] AluMul  = 6'd27, AluMulh = 6'd28, AluMulhsu = 6'd29;
  localparam logic [5:0] AluMulhu = 6'd30, AluDiv = 6'd31, AluDivu   = 6'd32;
  localparam logic [5:0] AluRem  = 6'd33, AluRemu = 6'd34;
`endif
  localparam logic [1:0] OpTypeNone = 2'd0, OpTypeReg = 2'd1, OpTypeImm = 2'd2, OpTypePc = 2'd3;

  localparam logic [6:0] OpcLui    = 7'b0110111, OpcAuipc = 7'b0010111, OpcJal   = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111, OpcBranch = 7'b1100011, OpcLoad = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011, OpcOpImm = 7'b0010011, OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  typedef struct packed {
    logic [4:0]  srcreg1;
    logic [4:0]  srcreg2;
    logic [4:0]  dstreg;
    logic [31:0] imm;
    logic [5:0]  alucode;
    logic [1:0]  aluop1_type;
    logic [1:0]  aluop2_type;
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic        is_halt;
    logic        illegal;
  } bundle_t;

  logic [31:0]     ir_mem [DEPTH];
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [AW:0]     wr_ptr_q, rd_ptr_q, count_w;
  logic            full, empty, push, pop, halt_fire;
  logic            out_valid_q, out_valid_d, halted_q;
  logic [PC_W-1:0] pc_q;
  bundle_t         bundle_q, dec;
  logic [31:0]     head_ir, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic            use_rs1, use_rs2, use_rd, bad;

  assign count_w   = wr_ptr_q - rd_ptr_q;
  assign full      = (count_w == CW'(DEPTH));
  assign empty     = (count_w == '0);
  assign in_ready  = !full && !halted_q && !flush && !rst;
  assign push      = in_valid && in_ready;
  assign halt_fire = out_valid_q && out_ready && bundle_q.is_halt;
  // A consumed halt leaves the output register empty, so no pop on that edge.
  assign pop       = !empty && (!out_valid_q || out_ready) && !flush && !halt_fire;

  assign head_ir = ir_mem[rd_ptr_q[AW-1:0]];
  assign opcode  = head_ir[6:0];
  assign f3      = head_ir[14:12];
  assign f7      = head_ir[31:25];
  assign imm_i   = {{20{head_ir[31]}}, head_ir[31:20]};
  assign imm_s   = {{20{head_ir[31]}}, head_ir[31:25], head_ir[11:7]};
  assign imm_b   = {{19{head_ir[31]}}, head_ir[31], head_ir[7], head_ir[30:25], head_ir[11:8], 1'b0};
  assign imm_u   = {head_ir[31:12], 12'd0};
  assign imm_j   = {{11{head_ir[31]}}, head_ir[31], head_ir[19:12], head_ir[20], head_ir[30:21],
                    1'b0};

  // Combinational decode of the queue head; illegal words collapse to a NOP bundle.
  always_comb begin
    dec         = '0;
    dec.alucode = AluNop;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    use_rd      = 1'b0;
    bad         = 1'b0;
    case (opcode)
      OpcLui: begin
        dec.alucode = AluLui; dec.aluop2_type = OpTypeImm; dec.reg_we = 1'b1;
        dec.imm = imm_u; use_rd = 1'b1;
      end
      OpcAuipc: begin
        dec.alucode = AluAdd; dec.aluop1_type = OpTypePc; dec.aluop2_type = OpTypeImm;
        dec.reg_we = 1'b1; dec.imm = imm_u; use_rd = 1'b1;
      end
      OpcJal: begin
        dec.alucode = AluJal; dec.aluop1_type = OpTypePc; dec.aluop2_type = OpTypeImm;
        dec.reg_we = 1'b1; dec.imm = imm_j; use_rd = 1'b1;
      end
      OpcJalr: begin
        dec.alucode = AluJalr; dec.aluop1_type = OpTypeReg; dec.aluop2_type = OpTypeImm;
        dec.reg_we = 1'b1; dec.imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
        bad = (f3 != 3'b000);
      end
      OpcBranch: begin
        dec.aluop1_type = OpTypeReg; dec.aluop2_type = OpTypeReg; dec.imm = imm_b;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'b000:  dec.alucode = AluBeq;
          3'b001:  dec.alucode = AluBne;
          3'b100:  dec.alucode = AluBlt;
          3'b101:  dec.alucode = AluBge;
          3'b110:  dec.alucode = AluBltu;
          3'b111:  dec.alucode = AluBgeu;
          default: bad = 1'b1;
        endcase
      end
      OpcLoad: begin
        dec.aluop1_type = OpTypeReg; dec.aluop2_type = OpTypeImm; dec.reg_we = 1'b1;
        dec.is_load = 1'b1; dec.imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
        case (f3)
          3'b000:  dec.alucode = AluLb;
          3'b001:  dec.alucode = AluLh;
          3'b010:  dec.alucode = AluLw;
          3'b100:  dec.alucode = AluLbu;
          3'b101:  dec.alucode = AluLhu;
          default: bad = 1'b1;
        endcase
      end
      OpcStore: begin
        dec.aluop1_type = OpTypeReg; dec.aluop2_type = OpTypeImm; dec.is_store = 1'b1;
        dec.imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'b000:  dec.alucode = AluSb;
          3'b001:  dec.alucode = AluSh;
          3'b010:  dec.alucode = AluSw;
          default: bad = 1'b1;
        endcase
      end
      OpcOpImm: begin
        dec.aluop1_type = OpTypeReg; dec.aluop2_type = OpTypeImm; dec.reg_we = 1'b1;
        dec.imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
        case (f3)
          3'b000: dec.alucode = AluAdd;
          3'b010: dec.alucode = AluSlt;
          3'b011: dec.alucode = AluSltu;
          3'b100: dec.alucode = AluXor;
          3'b110: dec.alucode = AluOr;
          3'b111: dec.alucode = AluAnd;
          3'b001: begin dec.alucode = AluSll; bad = (f7 != 7'b0000000); end
          default: begin
            dec.alucode = (f7 == 7'b0100000) ? AluSra : AluSrl;
            bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          end
        endcase
      end
      OpcOp: begin
        dec.aluop1_type = OpTypeReg; dec.aluop2_type = OpTypeReg; dec.reg_we = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec.alucode = AluAdd;
            3'b001:  dec.alucode = AluSll;
            3'b010:  dec.alucode = AluSlt;
            3'b011:  dec.alucode = AluSltu;
            3'b100:  dec.alucode = AluXor;
            3'b101:  dec.alucode = AluSrl;
            3'b110:  dec.alucode = AluOr;
            default: dec.alucode = AluAnd;
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'b000:  dec.alucode = AluSub;
            3'b101:  dec.alucode = AluSra;
            default: bad = 1'b1;
          endcase
        end
`ifdef DECODE_RV32M_EN
        else if (f7 == 7'b0000001) begin
          case (f3)
            3'b000:  dec.alucode = AluMul;
            3'b001:  dec.alucode = AluMulh;
            3'b010:  dec.alucode = AluMulhsu;
            3'b011:  dec.alucode = AluMulhu;
            3'b100:  dec.alucode = AluDiv;
            3'b101:  dec.alucode = AluDivu;
            3'b110:  dec.alucode = AluRem;
            default: dec.alucode = AluRemu;
          endcase
        end
`endif
        else begin
          bad = 1'b1;
        end
      end
      OpcSystem: begin
        // Only ECALL is supported; it acts as the halt instruction.
        dec.is_halt = 1'b1; dec.imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
        bad = (head_ir != 32'h0000_0073);
      end
      default: bad = 1'b1;
    endcase
    dec.srcreg1 = use_rs1 ? head_ir[19:15] : 5'd0;
    dec.srcreg2 = use_rs2 ? head_ir[24:20] : 5'd0;
    dec.dstreg  = use_rd  ? head_ir[11:7]  : 5'd0;
    if (bad) begin
      dec         = '0;
      dec.alucode = AluNop;
      dec.illegal = 1'b1;
    end
  end

  // Output-register valid: flush or a consumed halt empties it, a pop fills it.
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush || halt_fire) begin
      out_valid_d = 1'b0;
    end else if (pop) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Queue storage; entries need no reset because reads are gated by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      ir_mem[wr_ptr_q[AW-1:0]] <= in_ir;
      pc_mem[wr_ptr_q[AW-1:0]] <= in_pc;
    end
  end

  // Pointers, sticky halt and the decoded output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      pc_q        <= '0;
      bundle_q    <= '0;
    end else begin
      if (flush || halt_fire) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (halt_fire) halted_q <= 1'b1;
      out_valid_q <= out_valid_d;
      if (pop) begin
        bundle_q <= dec;
        pc_q     <= pc_mem[rd_ptr_q[AW-1:0]];
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign out_pc          = pc_q;
  assign out_srcreg1_num = bundle_q.srcreg1;
  assign out_srcreg2_num = bundle_q.srcreg2;
  assign out_dstreg_num  = bundle_q.dstreg;
  assign out_imm         = bundle_q.imm;
  assign out_alucode     = bundle_q.alucode;
  assign out_aluop1_type = bundle_q.aluop1_type;
  assign out_aluop2_type = bundle_q.aluop2_type;
  assign out_reg_we      = bundle_q.reg_we;
  assign out_is_load     = bundle_q.is_load;
  assign out_is_store    = bundle_q.is_store;
  assign out_is_halt     = bundle_q.is_halt;
  assign out_illegal     = bundle_q.illegal;
  assign halted          = halted_q;
  assign count           = count_w;

endmodule
